sti_receiver: RTL and testbench

// - Serial-to-parallel receive end of the STI link: captures a frame of so_data/so_valid bits, rebuilds the word, and writes it bytewise into pixel memory.
// - After the last frame it zero-pads the remaining pixel addresses and raises pixel_finish.
// - Sits between the STI serial link and the 256-byte pixel RAM, mirroring the transmit serializer's framing.

---
 rtl/sti_pkg.sv | 36 +++
 rtl/sti_rx_shift.sv | 87 ++++++++
 rtl/sti_receiver.sv | 152 +++++++++++++++
 tb/tb_sti_receiver.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sti_pkg.sv
// Shared definitions for the STI link: length encoding, frame-size helpers
// and the receive/writer state enums used by both link ends.
package sti_pkg;

  localparam logic [1:0] LEN_8  = 2'd0;
  localparam logic [1:0] LEN_16 = 2'd1;
  localparam logic [1:0] LEN_24 = 2'd2;
  localparam logic [1:0] LEN_32 = 2'd3;

  typedef enum logic {
    RX_IDLE,
    RX_SHIFT
  } rx_state_e;

  typedef enum logic [1:0] {
    W_IDLE,
    W_BYTES,
    W_PAD,
    W_DONE
  } wr_state_e;

  // Frame length in bits for a length code (8, 16, 24 or 32).
  function automatic logic [5:0] len_bits(input logic [1:0] len);
    return 6'({len, 3'b000}) + 6'd8;
  endfunction

  function automatic logic [31:0] len_mask(input logic [1:0] len);
    case (len)
      LEN_8:   return 32'h0000_00FF;
      LEN_16:  return 32'h0000_FFFF;
      LEN_24:  return 32'h00FF_FFFF;
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction

endpackage

// File: rtl/sti_rx_shift.sv
// STI bit capture: shifts in one frame, counts bits and judges the frame
// length when si_valid drops.
module sti_rx_shift
  import sti_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [1:0]  cfg_length,
  input  logic        cfg_msb,
  input  logic        cfg_last,
  input  logic        si_data,
  input  logic        si_valid,
  output logic [31:0] word_data,
  output logic        word_valid,
  output logic        frame_ok,
  output logic        frame_bad,
  output logic [31:0] frame_word,
  output logic [1:0]  frame_len,
  output logic        frame_last
);

  rx_state_e   state;
  logic [31:0] sr;
  logic [5:0]  bit_cnt;
  logic [1:0]  len_q;
  logic        msb_q;
  logic        last_q;
  logic        frame_end;

  // The frame is judged in the first cycle si_valid is seen low.
  assign frame_end  = enable && (state == RX_SHIFT) && !si_valid;
  assign frame_ok   = frame_end && (bit_cnt == len_bits(len_q));
  assign frame_bad  = frame_end && (bit_cnt != len_bits(len_q));
  assign frame_word = sr & len_mask(len_q);
  assign frame_len  = len_q;
  assign frame_last = last_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= RX_IDLE;
      sr         <= '0;
      bit_cnt    <= '0;
      len_q      <= LEN_8;
      msb_q      <= 1'b0;
      last_q     <= 1'b0;
      word_data  <= '0;
      word_valid <= 1'b0;
    end else begin
      word_valid <= 1'b0;
      if (!enable) begin
        state <= RX_IDLE;
      end else begin
        case (state)
          RX_IDLE: begin
            if (si_valid) begin
              state   <= RX_SHIFT;
              len_q   <= cfg_length;
              msb_q   <= cfg_msb;
              last_q  <= cfg_last;
              sr      <= {31'd0, si_data};
              bit_cnt <= 6'd1;
            end
          end
          RX_SHIFT: begin
            if (si_valid) begin
              if (msb_q)
                sr <= {sr[30:0], si_data};
              else if (bit_cnt < 6'd32)
                sr[bit_cnt[4:0]] <= si_data;
              if (bit_cnt < 6'd33)
                bit_cnt <= bit_cnt + 6'd1;
            end else begin
              state <= RX_IDLE;
              if (frame_ok) begin
                word_data  <= frame_word;
                word_valid <= 1'b1;
              end
            end
          end
          default: state <= RX_IDLE;
        endcase
      end
    end
  end

endmodule

// File: rtl/sti_receiver.sv
// STI receive end: buffers one completed frame, writes it bytewise (MSB byte
// first) into pixel RAM and zero-pads the RAM after the last frame.
module sti_receiver
  import sti_pkg::*;
#(
  parameter int         ADDR_W    = 8,
  parameter logic [7:0] PAD_VALUE = 8'h00
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        cfg_length,
  input  logic              cfg_msb,
  input  logic              cfg_last,
  input  logic              si_data,
  input  logic              si_valid,
  output logic [31:0]       word_data,
  output logic              word_valid,
  output logic              pixel_wr,
  output logic [ADDR_W-1:0] pixel_addr,
  output logic [7:0]        pixel_dataout,
  output logic              pixel_finish,
  output logic              err_frame
);

  wr_state_e         wstate;
  logic              frame_ok;
  logic              frame_bad;
  logic [31:0]       frame_word;
  logic [1:0]        frame_len;
  logic              frame_last;
  logic              hold_full;
  logic [31:0]       hold_word;
  logic [1:0]        hold_len;
  logic              hold_last;
  logic [31:0]       hold_aligned;
  logic [31:0]       wr_sr;
  logic [1:0]        bytes_left;
  logic              wr_last;
  logic [ADDR_W-1:0] addr;
  logic              pop;

  sti_rx_shift u_rx (
    .clk        (clk),
    .reset      (reset),
    .enable     (wstate != W_DONE),
    .cfg_length (cfg_length),
    .cfg_msb    (cfg_msb),
    .cfg_last   (cfg_last),
    .si_data    (si_data),
    .si_valid   (si_valid),
    .word_data  (word_data),
    .word_valid (word_valid),
    .frame_ok   (frame_ok),
    .frame_bad  (frame_bad),
    .frame_word (frame_word),
    .frame_len  (frame_len),
    .frame_last (frame_last)
  );

  assign pop          = (wstate == W_IDLE) && hold_full;
  // Left-align the held word so bytes always leave from bits [31:24].
  assign hold_aligned = hold_word << (6'd32 - len_bits(hold_len));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wstate        <= W_IDLE;
      hold_full     <= 1'b0;
      hold_word     <= '0;
      hold_len      <= LEN_8;
      hold_last     <= 1'b0;
      wr_sr         <= '0;
      bytes_left    <= '0;
      wr_last       <= 1'b0;
      addr          <= '0;
      pixel_wr      <= 1'b0;
      pixel_addr    <= '0;
      pixel_dataout <= '0;
      pixel_finish  <= 1'b0;
      err_frame     <= 1'b0;
    end else begin
      err_frame <= frame_bad || (frame_ok && hold_full && !pop);

      // NOTE: both writes below are non-blocking, so a push in the pop cycle
      // wins and the hold register stays full with the new frame.
      if (pop)
        hold_full <= 1'b0;
      if (frame_ok && (!hold_full || pop)) begin
        hold_full <= 1'b1;
        hold_word <= frame_word;
        hold_len  <= frame_len;
        hold_last <= frame_last;
      end

      case (wstate)
        W_IDLE: begin
          pixel_wr <= 1'b0;
          if (hold_full) begin
            pixel_wr      <= 1'b1;
            pixel_addr    <= addr;
            pixel_dataout <= hold_aligned[31:24];
            wr_sr         <= {hold_aligned[23:0], 8'h00};
            bytes_left    <= hold_len;
            wr_last       <= hold_last;
            addr          <= addr + ADDR_W'(1);
            wstate        <= W_BYTES;
          end
        end
        W_BYTES: begin
          if (bytes_left != 2'd0) begin
            pixel_wr      <= 1'b1;
            pixel_addr    <= addr;
            pixel_dataout <= wr_sr[31:24];
            wr_sr         <= {wr_sr[23:0], 8'h00};
            bytes_left    <= bytes_left - 2'd1;
            addr          <= addr + ADDR_W'(1);
          end else if (!wr_last) begin
            pixel_wr <= 1'b0;
            wstate   <= W_IDLE;
          end else if (addr == '0) begin
            // Last frame filled the top address already: nothing to pad.
            pixel_wr     <= 1'b0;
            pixel_finish <= 1'b1;
            wstate       <= W_DONE;
          end else begin
            pixel_wr      <= 1'b1;
            pixel_addr    <= addr;
            pixel_dataout <= PAD_VALUE;
            addr          <= addr + ADDR_W'(1);
            wstate        <= W_PAD;
          end
        end
        W_PAD: begin
          if (addr == '0) begin
            pixel_wr     <= 1'b0;
            pixel_finish <= 1'b1;
            wstate       <= W_DONE;
          end else begin
            pixel_wr      <= 1'b1;
            pixel_addr    <= addr;
            pixel_dataout <= PAD_VALUE;
            addr          <= addr + ADDR_W'(1);
          end
        end
        default: begin
          pixel_wr     <= 1'b0;
          pixel_finish <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sti_receiver.sv
// Directed bench for sti_receiver: framing, byte order, padding, overflow
// drop and asynchronous reset, with hand-computed expectations.
module tb_sti_receiver;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [1:0]  cfg_length = 2'd0;
  logic        cfg_msb = 1'b0;
  logic        cfg_last = 1'b0;
  logic        si_data = 1'b0;
  logic        si_valid = 1'b0;
  logic [31:0] word_data;
  logic        word_valid;
  logic        pixel_wr;
  logic [7:0]  pixel_addr;
  logic [7:0]  pixel_dataout;
  logic        pixel_finish;
  logic        err_frame;

  always #5 clk = ~clk;

  sti_receiver #(.ADDR_W(8), .PAD_VALUE(8'h00)) dut (
    .clk           (clk),
    .reset         (reset),
    .cfg_length    (cfg_length),
    .cfg_msb       (cfg_msb),
    .cfg_last      (cfg_last),
    .si_data       (si_data),
    .si_valid      (si_valid),
    .word_data     (word_data),
    .word_valid    (word_valid),
    .pixel_wr      (pixel_wr),
    .pixel_addr    (pixel_addr),
    .pixel_dataout (pixel_dataout),
    .pixel_finish  (pixel_finish),
    .err_frame     (err_frame)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [7:0] addr;
    logic [7:0] data;
    int         cyc;
  } wr_t;

  wr_t         wr_q[$];
  int          cyc = 0;
  int          n_wv = 0;
  int          n_err = 0;
  int          fin_cyc = -1;
  logic [31:0] last_word = '0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (pixel_wr) wr_q.push_back('{pixel_addr, pixel_dataout, cyc});
    if (word_valid) begin
      n_wv++;
      last_word = word_data;
    end
    if (err_frame) n_err++;
    if (pixel_finish && fin_cyc < 0) fin_cyc = cyc;
  end

  // Drives nbits bits of val; returns right after si_valid is dropped.
  task automatic send_frame(input logic [1:0] len, input logic msb, input logic last,
                            input int nbits, input logic [31:0] val);
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk);
      cfg_length = len;
      cfg_msb    = msb;
      cfg_last   = last;
      si_valid   = 1'b1;
      si_data    = msb ? val[nbits-1-i] : val[i];
    end
    @(negedge clk);
    si_valid = 1'b0;
    si_data  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  int          w0, e0, wv0, bad, last_idx;
  logic [7:0]  exp_b[4];

  initial begin
    // Reset state
    #12;
    check("rst_word_data", word_data, 32'h0);
    check("rst_word_valid", word_valid, 0);
    check("rst_pixel_wr", pixel_wr, 0);
    check("rst_pixel_addr", pixel_addr, 0);
    check("rst_finish", pixel_finish, 0);
    check("rst_err", err_frame, 0);
    @(negedge clk);
    reset = 1'b1;
    idle(2);

    // 8-bit MSB-first 0xA5, not last: latency and single write at addr 0
    w0 = wr_q.size(); wv0 = n_wv;
    send_frame(2'd0, 1'b1, 1'b0, 8, 32'hA5);
    @(negedge clk);
    check("a5_word_valid", word_valid, 1);
    check("a5_word_data", word_data, 32'h0000_00A5);
    check("a5_wr_early", pixel_wr, 0);
    @(negedge clk);
    check("a5_wr", pixel_wr, 1);
    check("a5_addr", pixel_addr, 8'h00);
    check("a5_data", pixel_dataout, 8'hA5);
    idle(5);
    check("a5_nwrites", wr_q.size() - w0, 1);
    check("a5_nwv", n_wv - wv0, 1);
    check("a5_nerr", n_err, 0);

    // 32-bit LSB-first 0x12345678: bytes 12,34,56,78 at 1..4, consecutive
    w0 = wr_q.size();
    exp_b = '{8'h12, 8'h34, 8'h56, 8'h78};
    send_frame(2'd3, 1'b0, 1'b0, 32, 32'h1234_5678);
    idle(8);
    check("w32_word", last_word, 32'h1234_5678);
    check("w32_nwrites", wr_q.size() - w0, 4);
    if (wr_q.size() >= w0 + 4) begin
      for (int i = 0; i < 4; i++) begin
        check($sformatf("w32_addr%0d", i), wr_q[w0+i].addr, 8'(i + 1));
        check($sformatf("w32_data%0d", i), wr_q[w0+i].data, exp_b[i]);
        check($sformatf("w32_cyc%0d", i), wr_q[w0+i].cyc - wr_q[w0].cyc, i);
      end
    end

    // 16-bit frames with 15 then 17 bits: two errors, no writes
    w0 = wr_q.size(); e0 = n_err; wv0 = n_wv;
    send_frame(2'd1, 1'b1, 1'b0, 15, 32'h0000_7FFF);
    idle(3);
    send_frame(2'd1, 1'b1, 1'b0, 17, 32'h0001_FFFF);
    idle(6);
    check("len_nerr", n_err - e0, 2);
    check("len_nwrites", wr_q.size() - w0, 0);
    check("len_nwv", n_wv - wv0, 0);

    // Back-to-back 8-bit frames, 1-cycle gap: addr 5 and 6, no error
    w0 = wr_q.size(); e0 = n_err;
    send_frame(2'd0, 1'b1, 1'b0, 8, 32'h11);
    send_frame(2'd0, 1'b1, 1'b0, 8, 32'h22);
    idle(6);
    check("b2b_nerr", n_err - e0, 0);
    check("b2b_nwrites", wr_q.size() - w0, 2);
    if (wr_q.size() >= w0 + 2) begin
      check("b2b_addr0", wr_q[w0].addr, 8'h05);
      check("b2b_data0", wr_q[w0].data, 8'h11);
      check("b2b_addr1", wr_q[w0+1].addr, 8'h06);
      check("b2b_data1", wr_q[w0+1].data, 8'h22);
    end

    // 24-bit MSB-first 0xC0FFEE at 7..9, bringing addr to 10
    w0 = wr_q.size();
    send_frame(2'd2, 1'b1, 1'b0, 24, 32'h00C0_FFEE);
    idle(8);
    check("w24_nwrites", wr_q.size() - w0, 3);
    if (wr_q.size() >= w0 + 3) begin
      check("w24_addr2", wr_q[w0+2].addr, 8'h09);
      check("w24_data0", wr_q[w0].data, 8'hC0);
      check("w24_data2", wr_q[w0+2].data, 8'hEE);
    end

    // 24-bit LSB-first last frame 0xABCDEF at 10..12, then pad 13..255.
    // Two frames arrive during padding: the first is held, the second dropped.
    w0 = wr_q.size(); e0 = n_err; wv0 = n_wv;
    send_frame(2'd2, 1'b0, 1'b1, 24, 32'h00AB_CDEF);
    idle(4);
    send_frame(2'd0, 1'b1, 1'b0, 8, 32'h33);
    send_frame(2'd0, 1'b1, 1'b0, 8, 32'h44);
    idle(300);
    check("last_nerr", n_err - e0, 1);
    check("last_nwv", n_wv - wv0, 3);
    check("last_word", last_word, 32'h44);
    check("last_nwrites", wr_q.size() - w0, 246);
    if (wr_q.size() == w0 + 246) begin
      check("last_addr0", wr_q[w0].addr, 8'd10);
      check("last_data0", wr_q[w0].data, 8'hAB);
      check("last_data1", wr_q[w0+1].data, 8'hCD);
      check("last_data2", wr_q[w0+2].data, 8'hEF);
      bad = 0;
      for (int k = 0; k < 243; k++)
        if (wr_q[w0+3+k].addr != 8'(13 + k) || wr_q[w0+3+k].data != 8'h00) bad++;
      check("pad_bad_entries", bad, 0);
      last_idx = w0 + 245;
      check("pad_last_addr", wr_q[last_idx].addr, 8'hFF);
      check("finish_timing", fin_cyc - wr_q[last_idx].cyc, 1);
    end
    check("finish_high", pixel_finish, 1);

    // After finish: further frames are ignored silently
    w0 = wr_q.size(); e0 = n_err; wv0 = n_wv;
    send_frame(2'd0, 1'b1, 1'b0, 8, 32'h55);
    send_frame(2'd1, 1'b1, 1'b0, 5, 32'h1F);
    idle(6);
    check("done_nerr", n_err - e0, 0);
    check("done_nwv", n_wv - wv0, 0);
    check("done_nwrites", wr_q.size() - w0, 0);
    check("done_sticky", pixel_finish, 1);

    // Reset mid-frame
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      cfg_length = 2'd0; cfg_msb = 1'b1; cfg_last = 1'b0;
      si_valid = 1'b1; si_data = 1'(i);
    end
    #2 reset = 1'b0;
    si_valid = 1'b0;
    #1;
    check("rst1_finish", pixel_finish, 0);
    check("rst1_word", word_data, 32'h0);
    fin_cyc = -1;
    @(negedge clk);
    reset = 1'b1;
    idle(2);

    // Last 8-bit frame at addr 0, then reset mid-pad
    w0 = wr_q.size();
    send_frame(2'd0, 1'b1, 1'b1, 8, 32'h77);
    idle(20);
    check("pad2_active", pixel_wr, 1);
    if (wr_q.size() > w0) begin
      check("pad2_addr0", wr_q[w0].addr, 8'h00);
      check("pad2_data0", wr_q[w0].data, 8'h77);
    end
    #2 reset = 1'b0;
    #1;
    check("rst2_wr", pixel_wr, 0);
    check("rst2_addr", pixel_addr, 8'h00);
    check("rst2_finish", pixel_finish, 0);
    @(negedge clk);
    reset = 1'b1;
    idle(2);

    // Fresh frame after reset lands at addr 0
    w0 = wr_q.size(); e0 = n_err;
    send_frame(2'd0, 1'b1, 1'b0, 8, 32'h5A);
    idle(6);
    check("fresh_nwrites", wr_q.size() - w0, 1);
    if (wr_q.size() > w0) begin
      check("fresh_addr", wr_q[w0].addr, 8'h00);
      check("fresh_data", wr_q[w0].data, 8'h5A);
    end
    check("fresh_nerr", n_err - e0, 0);
    check("fresh_finish", pixel_finish, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
